processor_core: RTL and testbench



---
 rtl/processor_pkg.sv | 33 +++
 rtl/processor_ram.sv | 23 ++
 rtl/processor_regfile.sv | 39 +++
 rtl/processor_core.sv | 76 +++++++
 tb/tb_processor_core.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/processor_pkg.sv
// processor_pkg: shared ISA constants, instruction field positions and decode helper
// for processor_core.
package processor_pkg;
  localparam int WORD_W  = 32;
  localparam int IMM_W   = 16;
  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
    OP_ADDI, OP_LDI, OP_LD, OP_ST, OP_BEQ, OP_BNE, OP_JMP, OP_HALT
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [WORD_W-1:0] simm;
  } instr_t;

  function automatic instr_t decode(input logic [WORD_W-1:0] w);
    instr_t d;
    d.op   = op_e'(w[OP_LSB +: 4]);
    d.rd   = w[RD_LSB +: 4];
    d.rs1  = w[RS1_LSB +: 4];
    d.rs2  = w[RS2_LSB +: 4];
    d.simm = {{(WORD_W-IMM_W){w[IMM_W-1]}}, w[IMM_W-1:0]};
    return d;
  endfunction
endpackage

// File: rtl/processor_ram.sv
// processor_ram: unified instruction/data word RAM, combinational reads, write on rising edge.
module processor_ram
  import processor_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     iaddr_i,
  output logic [WORD_W-1:0] idata_o,
  input  logic [AW-1:0]     daddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] ddata_o
);
  logic [WORD_W-1:0] Mem [DEPTH];

  assign idata_o = Mem[iaddr_i];
  assign ddata_o = Mem[daddr_i];

  always_ff @(posedge clk_i)
    if (we_i) Mem[daddr_i] <= wdata_i;
endmodule

// File: rtl/processor_regfile.sv
// processor_regfile: 16 x 32 register bank (R0..R15), three combinational reads, one write.
// Define ZERO_REG_EN to hardwire R0 to zero.
module processor_regfile
  import processor_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [3:0]        ra_i,
  input  logic [3:0]        rb_i,
  input  logic [3:0]        rs_i,
  output logic [WORD_W-1:0] ra_o,
  output logic [WORD_W-1:0] rb_o,
  output logic [WORD_W-1:0] rs_o
);
`ifdef ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  if (1) begin : RegBank
    logic [WORD_W-1:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15;
    logic [15:0][WORD_W-1:0] regs_q, regs_d;
    assign regs_q = {R15, R14, R13, R12, R11, R10, R9, R8, R7, R6, R5, R4, R3, R2, R1, R0};
    always_comb begin
      regs_d = regs_q;
      if (we_i && !(ZeroReg && waddr_i == '0)) regs_d[waddr_i] = wdata_i;
    end
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) {R15, R14, R13, R12, R11, R10, R9, R8, R7, R6, R5, R4, R3, R2, R1, R0} <= '0;
      else {R15, R14, R13, R12, R11, R10, R9, R8, R7, R6, R5, R4, R3, R2, R1, R0} <= regs_d;
    assign ra_o = (ZeroReg && ra_i == '0) ? '0 : regs_q[ra_i];
    assign rb_o = (ZeroReg && rb_i == '0) ? '0 : regs_q[rb_i];
    assign rs_o = (ZeroReg && rs_i == '0) ? '0 : regs_q[rs_i];
  end
endmodule

// File: rtl/processor_core.sv
// processor_core: single-cycle 32-bit load/store CPU; fetch, decode, execute, retire per edge.
// Optional ZERO_REG_EN (in processor_regfile) makes R0 a constant zero.
module processor_core
  import processor_pkg::*;
#(
  parameter  int MEM_DEPTH = 256,
  parameter  int RESET_PC  = 0,
  localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              Clock,
  input  logic              Resetn,
  output logic [ADDR_W-1:0] Pc,
  output logic              Halted
);
  logic [ADDR_W-1:0] pc_q, pc_d, ea, br_tgt;
  logic              halted_q, halted_d, rf_we, mem_we;
  logic [WORD_W-1:0] instr, mem_rdata, rs1_v, rs2_v, rd_v, rf_wdata;
  instr_t            dec;

  processor_ram #(.DEPTH(MEM_DEPTH)) ram (
    .clk_i(Clock), .we_i(mem_we && Resetn), .iaddr_i(pc_q), .idata_o(instr),
    .daddr_i(ea), .wdata_i(rd_v), .ddata_o(mem_rdata)
  );

  processor_regfile register (
    .clk_i(Clock), .rst_ni(Resetn), .we_i(rf_we), .waddr_i(dec.rd), .wdata_i(rf_wdata),
    .ra_i(dec.rs1), .rb_i(dec.rs2), .rs_i(dec.rd), .ra_o(rs1_v), .rb_o(rs2_v), .rs_o(rd_v)
  );

  assign dec    = decode(instr);
  assign ea     = rs1_v[ADDR_W-1:0] + dec.simm[ADDR_W-1:0];
  assign br_tgt = pc_q + ADDR_W'(1) + dec.simm[ADDR_W-1:0];
  assign Pc     = pc_q;
  assign Halted = halted_q;

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = '0;
    mem_we   = 1'b0;
    pc_d     = pc_q + ADDR_W'(1);
    halted_d = halted_q;
    case (dec.op)
      OP_ADD:  begin rf_we = 1'b1; rf_wdata = rs1_v + rs2_v; end
      OP_SUB:  begin rf_we = 1'b1; rf_wdata = rs1_v - rs2_v; end
      OP_AND:  begin rf_we = 1'b1; rf_wdata = rs1_v & rs2_v; end
      OP_OR:   begin rf_we = 1'b1; rf_wdata = rs1_v | rs2_v; end
      OP_XOR:  begin rf_we = 1'b1; rf_wdata = rs1_v ^ rs2_v; end
      OP_SHL:  begin rf_we = 1'b1; rf_wdata = rs1_v << rs2_v[4:0]; end
      OP_SHR:  begin rf_we = 1'b1; rf_wdata = rs1_v >> rs2_v[4:0]; end
      OP_ADDI: begin rf_we = 1'b1; rf_wdata = rs1_v + dec.simm; end
      OP_LDI:  begin rf_we = 1'b1; rf_wdata = dec.simm; end
      OP_LD:   begin rf_we = 1'b1; rf_wdata = mem_rdata; end
      OP_ST:   mem_we = 1'b1;
      OP_BEQ:  pc_d = (rd_v == rs1_v) ? br_tgt : pc_d;
      OP_BNE:  pc_d = (rd_v != rs1_v) ? br_tgt : pc_d;
      OP_JMP:  pc_d = dec.simm[ADDR_W-1:0];
      OP_HALT: begin pc_d = pc_q; halted_d = 1'b1; end
      default: ;
    endcase
    // a halted core retires nothing further until reset
    if (halted_q) begin
      rf_we  = 1'b0;
      mem_we = 1'b0;
      pc_d   = pc_q;
    end
  end

  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      pc_q     <= ADDR_W'(RESET_PC);
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
endmodule

// File: tb/tb_processor_core.sv
// tb_processor_core: instruction-level reference model with a Pc/Halted scoreboard,
// directed programs from the test plan plus random programs.
module tb_processor_core;
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [7:0]  Pc;
  logic        Halted;
  logic [15:0][31:0] dregs;
  int total = 0, bad = 0;

  logic [31:0] img [256];
  logic [31:0] m_mem [256];
  logic [31:0] m_reg [16];
  int          m_pc;
  bit          m_halt;
  logic [8:0]  exp_q [$];

  processor_core dut (.Clock(Clock), .Resetn(Resetn), .Pc(Pc), .Halted(Halted));

  always #5 Clock = ~Clock;

  assign dregs = {dut.register.RegBank.R15, dut.register.RegBank.R14, dut.register.RegBank.R13,
                  dut.register.RegBank.R12, dut.register.RegBank.R11, dut.register.RegBank.R10,
                  dut.register.RegBank.R9,  dut.register.RegBank.R8,  dut.register.RegBank.R7,
                  dut.register.RegBank.R6,  dut.register.RegBank.R5,  dut.register.RegBank.R4,
                  dut.register.RegBank.R3,  dut.register.RegBank.R2,  dut.register.RegBank.R1,
                  dut.register.RegBank.R0};

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
    logic [31:0] i32;
    i32 = imm;
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], i32[15:0]};
  endfunction

  function automatic logic [31:0] rv(input int i);
    return (ZR && i == 0) ? 32'd0 : m_reg[i];
  endfunction

  // ISA-level interpreter: one call = one retired instruction
  task automatic model_step();
    logic [31:0] ins, a, b, d, simm, res, sum;
    int op, rd, ea, npc;
    bit wr;
    if (m_halt) return;
    ins  = m_mem[m_pc];
    op   = int'(ins[31:28]);
    rd   = int'(ins[27:24]);
    a    = rv(int'(ins[23:20]));
    b    = rv(int'(ins[19:16]));
    d    = rv(rd);
    simm = {{16{ins[15]}}, ins[15:0]};
    sum  = a + simm;
    ea   = int'(sum[7:0]);
    npc  = m_pc + 1;
    wr   = 1;
    res  = 0;
    case (op)
      1: res = a + b;
      2: res = a - b;
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = a << b[4:0];
      7: res = a >> b[4:0];
      8: res = sum;
      9: res = simm;
      10: res = m_mem[ea];
      11: begin wr = 0; m_mem[ea] = d; end
      12: begin wr = 0; if (d == a) npc = m_pc + 1 + $signed(ins[15:0]); end
      13: begin wr = 0; if (d != a) npc = m_pc + 1 + $signed(ins[15:0]); end
      14: begin wr = 0; npc = int'(ins[7:0]); end
      15: begin wr = 0; npc = m_pc; m_halt = 1; end
      default: wr = 0;
    endcase
    if (wr && !(ZR && rd == 0)) m_reg[rd] = res;
    m_pc = npc & 255;
  endtask

  function automatic int mem_diffs(input bit vs_model);
    int n = 0;
    for (int i = 0; i < 256; i++)
      if (dut.ram.Mem[i] !== (vs_model ? m_mem[i] : img[i])) n++;
    return n;
  endfunction

  task automatic clear_img(input bit rnd);
    for (int i = 0; i < 256; i++) img[i] = rnd ? $urandom : 32'd0;
  endtask

  task automatic run_prog(input string name, input int cycles);
    Resetn = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dut.ram.Mem[i] = img[i];
      m_mem[i] = img[i];
    end
    for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
    m_pc = 0;
    m_halt = 0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk({name, "_rst_pc"}, Pc, 0);
    chk({name, "_rst_halted"}, Halted, 0);
    chk({name, "_rst_regs"}, dregs, 0);
    chk({name, "_rst_mem_diffs"}, mem_diffs(0), 0);
    Resetn = 1'b1;
    repeat (cycles) begin
      @(posedge Clock);
      model_step();
      exp_q.push_back({m_halt, m_pc[7:0]});
    end
    @(negedge Clock);
    #1;
    for (int i = 0; i < 16; i++) chk($sformatf("%s_r%0d", name, i), dregs[i], rv(i));
    chk({name, "_mem_diffs"}, mem_diffs(1), 0);
  endtask

  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({Halted, Pc} !== e) begin
          bad++;
          $display("FAIL step: got halted=%0d pc=%0d want halted=%0d pc=%0d", Halted, Pc, e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    // arithmetic, memory and halt at word 7
    clear_img(0);
    img[0] = enc(9, 1, 0, 0, 5);
    img[1] = enc(9, 2, 0, 0, -3);
    img[2] = enc(1, 3, 1, 2, 0);
    img[3] = enc(2, 4, 2, 1, 0);
    img[4] = enc(9, 5, 0, 0, 'h1234);
    img[5] = enc(11, 5, 0, 0, 100);
    img[6] = enc(10, 6, 0, 0, 100);
    img[7] = enc(15, 0, 0, 0, 0);
    run_prog("arith", 20);
    chk("arith_r3", dregs[3], 32'd2);
    chk("arith_r4", dregs[4], 32'hFFFF_FFF8);
    chk("mem_r6", dregs[6], 32'h1234);
    chk("mem_100", dut.ram.Mem[100], 32'h1234);
    chk("halt_pc", Pc, 7);
    chk("halt_flag", Halted, 1);
    #2 Resetn = 1'b0;
    #1;
    chk("rst_pulse_pc", Pc, 0);
    chk("rst_pulse_halted", Halted, 0);

    // countdown loop then jump
    clear_img(0);
    img[0]  = enc(9, 1, 0, 0, 3);
    img[1]  = enc(8, 1, 1, 0, -1);
    img[2]  = enc(13, 1, 0, 0, -2);
    img[3]  = enc(14, 0, 0, 0, 'h10);
    img[16] = enc(15, 0, 0, 0, 0);
    run_prog("loop", 20);
    chk("loop_r1", dregs[1], 0);
    chk("loop_pc", Pc, 16);

    // R0 behaviour
    clear_img(0);
    img[0] = enc(9, 0, 0, 0, 9);
    img[1] = enc(1, 1, 0, 0, 0);
    img[2] = enc(15, 0, 0, 0, 0);
    run_prog("zreg", 8);
    chk("zreg_r0", dregs[0], ZR ? 0 : 9);
    chk("zreg_r1", dregs[1], ZR ? 0 : 18);

    // self-modifying: store an LDI over the next instruction
    clear_img(0);
    img[50] = enc(9, 2, 0, 0, 77);
    img[0]  = enc(10, 1, 0, 0, 50);
    img[1]  = enc(11, 1, 0, 0, 2);
    img[3]  = enc(15, 0, 0, 0, 0);
    run_prog("smc", 8);
    chk("smc_r2", dregs[2], 77);

    // random programs, including wrap-around and random self-modification
    for (int p = 0; p < 6; p++) begin
      clear_img(1);
      for (int i = 0; i < 256; i++)
        if ($urandom_range(0, 99) < 2) img[i][31:28] = 4'hF;
        else img[i][31:28] = 4'($urandom_range(0, 14));
      run_prog($sformatf("rnd%0d", p), 300);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
